// File: rtl/predicate_register_bank_if.sv
// ============================================================================
// Module      : predicate_register_bank_if
// Description : Read, write and fill signal bundle for predicate_register_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface predicate_register_bank_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_LANES  = 32
);
    logic [ADDR_WIDTH-1:0] read_addr1;
    logic [ADDR_WIDTH-1:0] read_addr2;
    logic [NUM_LANES-1:0]  data_out1;
    logic [NUM_LANES-1:0]  data_out2;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [NUM_LANES-1:0]  write_lane_mask;
    logic [NUM_LANES-1:0]  data_in;
    logic                  fill_start;
    logic [ADDR_WIDTH-1:0] fill_first;
    logic [ADDR_WIDTH-1:0] fill_last;
    logic                  fill_value;
    logic                  fill_busy;
    logic                  fill_done;

    modport master (
        output read_addr1, read_addr2,
        output write_enable, write_addr, write_lane_mask, data_in,
        output fill_start, fill_first, fill_last, fill_value,
        input  data_out1, data_out2, fill_busy, fill_done
    );

    modport slave (
        input  read_addr1, read_addr2,
        input  write_enable, write_addr, write_lane_mask, data_in,
        input  fill_start, fill_first, fill_last, fill_value,
        output data_out1, data_out2, fill_busy, fill_done
    );
endinterface

`default_nettype wire

// File: rtl/predicate_register_bank.sv
// ============================================================================
// Module      : predicate_register_bank
// Description : Two-read / one-write predicate register file with a range-fill
//               engine. Define PRF_BYPASS_EN to forward port writes to reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module predicate_register_bank #(
    parameter int ADDR_WIDTH    = 5,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_LANES     = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    predicate_register_bank_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0]   c_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGISTERS);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_REG = ADDR_WIDTH'(NUM_REGISTERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    fill_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_end;
    logic                  r_fill_value;
    logic                  r_busy;
    logic                  r_done;

    logic [NUM_LANES-1:0]  w_regs [NUM_REGISTERS];
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic                  w_fill_active;
    logic                  w_start_ok;

    assign w_fill_active = (r_state == FILL);
    assign w_ptr_next    = (r_ptr == c_LAST_REG) ? '0 : r_ptr + 1'b1;
    assign w_start_ok    = bus.fill_start
                         && ({1'b0, bus.fill_first} < c_NUM_REGS)
                         && ({1'b0, bus.fill_last}  < c_NUM_REGS);

    // ------------------------------------------------------------------------
    // Fill sequencer: outputs registered alongside the state transitions
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_end        <= '0;
            r_fill_value <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_state      <= FILL;
                        r_ptr        <= bus.fill_first;
                        r_end        <= bus.fill_last;
                        r_fill_value <= bus.fill_value;
                        r_busy       <= 1'b1;
                    end
                end
                FILL: begin
                    r_ptr <= w_ptr_next;
                    if (r_ptr == r_end) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fill_busy = r_busy;
    assign bus.fill_done = r_done;

    // ------------------------------------------------------------------------
    // Storage: the port write is layered over the fill write so masked lanes
    // win on a same-register collision.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_reg
        logic [NUM_LANES-1:0] r_q;
        logic [NUM_LANES-1:0] w_next;
        logic                 w_fill_hit;
        logic                 w_port_hit;

        assign w_fill_hit = w_fill_active && (r_ptr == ADDR_WIDTH'(i));
        assign w_port_hit = bus.write_enable && (bus.write_addr == ADDR_WIDTH'(i));

        always_comb begin
            w_next = r_q;
            if (w_fill_hit) begin
                w_next = {NUM_LANES{r_fill_value}};
            end
            if (w_port_hit) begin
                w_next = (bus.data_in & bus.write_lane_mask)
                       | (w_next & ~bus.write_lane_mask);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_q <= '0;
            end else if (w_fill_hit || w_port_hit) begin
                r_q <= w_next;
            end
        end

        assign w_regs[i] = r_q;
    end

    // ------------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------------
    logic                 w_rd1_ok;
    logic                 w_rd2_ok;
    logic [NUM_LANES-1:0] w_stored1;
    logic [NUM_LANES-1:0] w_stored2;

    assign w_rd1_ok  = ({1'b0, bus.read_addr1} < c_NUM_REGS);
    assign w_rd2_ok  = ({1'b0, bus.read_addr2} < c_NUM_REGS);
    assign w_stored1 = w_rd1_ok ? w_regs[bus.read_addr1] : '0;
    assign w_stored2 = w_rd2_ok ? w_regs[bus.read_addr2] : '0;

`ifdef PRF_BYPASS_EN
    // Only port writes are forwarded; fill writes appear after the edge.
    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = bus.write_enable && w_rd1_ok && (bus.read_addr1 == bus.write_addr);
    assign w_byp2 = bus.write_enable && w_rd2_ok && (bus.read_addr2 == bus.write_addr);

    assign bus.data_out1 = w_byp1 ? ((bus.data_in & bus.write_lane_mask)
                                   | (w_stored1 & ~bus.write_lane_mask))
                                  : w_stored1;
    assign bus.data_out2 = w_byp2 ? ((bus.data_in & bus.write_lane_mask)
                                   | (w_stored2 & ~bus.write_lane_mask))
                                  : w_stored2;
`else
    assign bus.data_out1 = w_stored1;
    assign bus.data_out2 = w_stored2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_predicate_register_bank.sv
// ============================================================================
// Module      : tb_predicate_register_bank
// Description : Directed self-checking bench for predicate_register_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_predicate_register_bank;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    predicate_register_bank_if #(.ADDR_WIDTH(5), .NUM_LANES(32)) bus ();
    predicate_register_bank_if #(.ADDR_WIDTH(5), .NUM_LANES(32)) bus_s ();

    predicate_register_bank #(
        .ADDR_WIDTH(5), .NUM_REGISTERS(32), .NUM_LANES(32)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Smaller bank so out-of-range addresses exist
    predicate_register_bank #(
        .ADDR_WIDTH(5), .NUM_REGISTERS(20), .NUM_LANES(32)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] mask;
        logic [31:0] din;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.read_addr1 = '0;      bus.read_addr2 = '0;
        bus.write_enable = 1'b0;  bus.write_addr = '0;
        bus.write_lane_mask = '0; bus.data_in = '0;
        bus.fill_start = 1'b0;    bus.fill_first = '0;
        bus.fill_last = '0;       bus.fill_value = 1'b0;
        bus_s.read_addr1 = '0;      bus_s.read_addr2 = '0;
        bus_s.write_enable = 1'b0;  bus_s.write_addr = '0;
        bus_s.write_lane_mask = '0; bus_s.data_in = '0;
        bus_s.fill_start = 1'b0;    bus_s.fill_first = '0;
        bus_s.fill_last = '0;       bus_s.fill_value = 1'b0;
    endtask

    // Reads only used while the bank is quiescent
    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.read_addr1 = a;
        #1;
        d = bus.data_out1;
    endtask

    task automatic rd_s(input logic [4:0] a, output logic [31:0] d);
        bus_s.read_addr1 = a;
        #1;
        d = bus_s.data_out1;
    endtask

    initial begin
        logic [31:0] d;
        int n_busy, n_done, done_at;
        int seen_busy, seen_done;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b1, 5'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  5'd4,  32'hFFFFFFFF, 32'h00000000};
        vecs[1] = '{1'b1, 5'd3,  32'h0000FFFF, 32'hAAAAAAAA, 5'd3,  5'd2,  32'hFFFFAAAA, 32'h00000000};
        vecs[2] = '{1'b1, 5'd31, 32'hF0F0F0F0, 32'h12345678, 5'd31, 5'd3,  32'h10305070, 32'hFFFFAAAA};
        vecs[3] = '{1'b1, 5'd0,  32'h00000001, 32'hFFFFFFFF, 5'd0,  5'd31, 32'h00000001, 32'h10305070};
        vecs[4] = '{1'b1, 5'd2,  32'hFFFFFFFF, 32'h0000FFFF, 5'd2,  5'd0,  32'h0000FFFF, 32'h00000001};
        vecs[5] = '{1'b0, 5'd5,  32'h000000FF, 32'h000000FF, 5'd5,  5'd2,  32'h00000000, 32'h0000FFFF};
        vecs[6] = '{1'b1, 5'd3,  32'h00000000, 32'h00000000, 5'd3,  5'd31, 32'hFFFFAAAA, 32'h10305070};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.read_addr2 = 5'd31;
        #1;
        check("reset_busy",  {31'd0, bus.fill_busy}, 32'd0);
        check("reset_done",  {31'd0, bus.fill_done}, 32'd0);
        check("reset_rd1",   bus.data_out1, 32'd0);
        check("reset_rd2",   bus.data_out2, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.write_enable    = vecs[i].we;
            bus.write_addr      = vecs[i].waddr;
            bus.write_lane_mask = vecs[i].mask;
            bus.data_in         = vecs[i].din;
            @(posedge clk);
            @(negedge clk);
            bus.write_enable = 1'b0;
            bus.read_addr1   = vecs[i].ra1;
            bus.read_addr2   = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d_rd1", i), bus.data_out1, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), bus.data_out2, vecs[i].e2);
        end

        // Wrapped fill 30..1 with an ignored restart and a port write elsewhere
        @(negedge clk);
        bus.fill_start = 1'b1; bus.fill_first = 5'd30; bus.fill_last = 5'd1; bus.fill_value = 1'b1;
        @(posedge clk);
        n_busy = 0; n_done = 0; done_at = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.fill_start      = (c == 1);
            bus.fill_first      = 5'd10;
            bus.fill_last       = 5'd10;
            bus.write_enable    = (c == 2);
            bus.write_addr      = 5'd20;
            bus.write_lane_mask = 32'hFFFFFFFF;
            bus.data_in         = 32'hDEADBEEF;
            #1;
            if (bus.fill_busy) n_busy++;
            if (bus.fill_done) begin n_done++; done_at = c; end
        end
        check("wrap_busy_cycles", 32'(n_busy), 32'd4);
        check("wrap_done_pulses", 32'(n_done), 32'd1);
        check("wrap_done_cycle",  32'(done_at), 32'd4);
        rd(5'd30, d); check("wrap_reg30", d, 32'hFFFFFFFF);
        rd(5'd31, d); check("wrap_reg31", d, 32'hFFFFFFFF);
        rd(5'd0,  d); check("wrap_reg0",  d, 32'hFFFFFFFF);
        rd(5'd1,  d); check("wrap_reg1",  d, 32'hFFFFFFFF);
        rd(5'd2,  d); check("wrap_reg2",  d, 32'h0000FFFF);
        rd(5'd29, d); check("wrap_reg29", d, 32'h00000000);
        rd(5'd10, d); check("ignored_restart_reg10", d, 32'h00000000);
        rd(5'd20, d); check("port_during_fill_reg20", d, 32'hDEADBEEF);

        // Single-register fill colliding with a masked port write
        @(negedge clk);
        bus.write_enable = 1'b1; bus.write_addr = 5'd5;
        bus.write_lane_mask = 32'hFFFFFFFF; bus.data_in = 32'hFFFFFFFF;
        @(negedge clk);
        bus.write_enable = 1'b0;
        bus.fill_start = 1'b1; bus.fill_first = 5'd5; bus.fill_last = 5'd5; bus.fill_value = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.fill_start = 1'b0;
        #1;
        check("single_busy", {31'd0, bus.fill_busy}, 32'd1);
        bus.write_enable = 1'b1; bus.write_addr = 5'd5;
        bus.write_lane_mask = 32'h00000001; bus.data_in = 32'h00000001;
        @(posedge clk);
        @(negedge clk);
        bus.write_enable = 1'b0;
        #1;
        check("single_done", {30'd0, bus.fill_busy, bus.fill_done}, 32'd1);
        rd(5'd5, d); check("collide_reg5", d, 32'h00000001);

        // Same-cycle read of the register being written
        @(negedge clk);
        bus.write_enable = 1'b1; bus.write_addr = 5'd7;
        bus.write_lane_mask = 32'hFFFFFFFF; bus.data_in = 32'h12345678;
        bus.read_addr1 = 5'd7; bus.read_addr2 = 5'd8;
        #1;
`ifdef PRF_BYPASS_EN
        check("same_cycle_rd7", bus.data_out1, 32'h12345678);
`else
        check("same_cycle_rd7", bus.data_out1, 32'h00000000);
`endif
        check("same_cycle_rd8", bus.data_out2, 32'h00000000);
        @(posedge clk);
        @(negedge clk);
        bus.write_enable = 1'b0;
        #1;
        check("after_edge_rd7", bus.data_out1, 32'h12345678);

        // Reset in the second cycle of a 10-register fill
        @(negedge clk);
        bus.fill_start = 1'b1; bus.fill_first = 5'd8; bus.fill_last = 5'd17; bus.fill_value = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.fill_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        bus.read_addr1 = 5'd3; bus.read_addr2 = 5'd8;
        #1;
        check("abort_busy", {31'd0, bus.fill_busy}, 32'd0);
        check("abort_done", {31'd0, bus.fill_done}, 32'd0);
        check("abort_rd3",  bus.data_out1, 32'd0);
        check("abort_rd8",  bus.data_out2, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_busy = 0; seen_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (bus.fill_busy) seen_busy++;
            if (bus.fill_done) seen_done++;
        end
        check("abort_no_busy", 32'(seen_busy), 32'd0);
        check("abort_no_done", 32'(seen_done), 32'd0);
        rd(5'd9,  d); check("abort_reg9",  d, 32'd0);
        rd(5'd12, d); check("abort_reg12", d, 32'd0);
        rd(5'd17, d); check("abort_reg17", d, 32'd0);
        rd(5'd20, d); check("abort_reg20", d, 32'd0);

        // Out-of-range handling on the 20-register bank
        @(negedge clk);
        bus_s.write_enable = 1'b1; bus_s.write_addr = 5'd19;
        bus_s.write_lane_mask = 32'hFFFFFFFF; bus_s.data_in = 32'hFFFF0000;
        @(negedge clk);
        bus_s.write_addr = 5'd25; bus_s.data_in = 32'hFFFFFFFF;
        @(negedge clk);
        bus_s.write_enable = 1'b0;
        bus_s.read_addr2 = 5'd25;
        rd_s(5'd19, d); check("small_reg19", d, 32'hFFFF0000);
        check("small_rd25", bus_s.data_out2, 32'd0);
        rd_s(5'd5, d); check("small_reg5", d, 32'd0);
        rd_s(5'd9, d); check("small_reg9", d, 32'd0);
        @(negedge clk);
        bus_s.fill_start = 1'b1; bus_s.fill_first = 5'd18; bus_s.fill_last = 5'd25; bus_s.fill_value = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_s.fill_start = 1'b0;
        #1;
        check("small_bad_fill_busy", {31'd0, bus_s.fill_busy}, 32'd0);
        bus_s.fill_start = 1'b1; bus_s.fill_last = 5'd1;
        @(posedge clk);
        n_busy = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus_s.fill_start = 1'b0;
            #1;
            if (bus_s.fill_busy) n_busy++;
        end
        check("small_wrap_busy_cycles", 32'(n_busy), 32'd4);
        rd_s(5'd19, d); check("small_wrap_reg19", d, 32'hFFFFFFFF);
        rd_s(5'd0,  d); check("small_wrap_reg0",  d, 32'hFFFFFFFF);
        rd_s(5'd1,  d); check("small_wrap_reg1",  d, 32'hFFFFFFFF);
        rd_s(5'd2,  d); check("small_wrap_reg2",  d, 32'd0);
        rd_s(5'd17, d); check("small_wrap_reg17", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/predicate_register_bank.md
PREDICATE_REGISTER_BANK -- requirements
Module: predicate_register_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter NUM_REGISTERS, default 32, number of predicate registers; must be at most 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_LANES, default 32, predicate bits (lanes) per register.
REQ-004 SHALL have ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- read_addr1, read_addr2  in  ADDR_WIDTH  read port addresses.
- data_out1, data_out2  out  NUM_LANES  read data.
- write_enable  in  1  port write strobe.
- write_addr  in  ADDR_WIDTH  port write address.
- write_lane_mask  in  NUM_LANES  per-lane write enable.
- data_in  in  NUM_LANES  port write data.
- fill_start  in  1  fill command strobe.
- fill_first, fill_last  in  ADDR_WIDTH  inclusive fill range.
- fill_value  in  1  value replicated to all lanes.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle completion pulse.

Function
REQ-005 Reads SHALL be combinational: data_outN = register[read_addrN]; an address >= NUM_REGISTERS SHALL read all zeros.
REQ-006 A port write SHALL occur at posedge clk when write_enable=1; only lanes with write_lane_mask[i]=1 update, others hold.
REQ-007 A port write to an address >= NUM_REGISTERS SHALL be ignored.
REQ-008 Fill FSM states SHALL be IDLE, FILL and DONE; reset state is IDLE.
REQ-009 IDLE->FILL SHALL occur on an edge with fill_start=1, fill_first<NUM_REGISTERS and fill_last<NUM_REGISTERS; the pointer loads fill_first and the end address latches fill_last.
REQ-010 A fill_start with an out-of-range address SHALL be ignored, with no state change.
REQ-011 fill_start SHALL be ignored in FILL and DONE.
REQ-012 In FILL, each edge SHALL write all lanes of register[ptr] to fill_value, latched at start.
REQ-013 After each FILL write, ptr SHALL advance by 1, wrapping NUM_REGISTERS-1 -> 0; fill_last < fill_first therefore fills a wrapped range.
REQ-014 The edge that writes the latched end address SHALL move FILL->DONE.
REQ-015 Fill length SHALL be ((last-first) mod NUM_REGISTERS)+1 cycles; first==last fills one register.
REQ-016 DONE SHALL last one cycle and then go to IDLE.
REQ-017 fill_busy SHALL be 1 exactly in FILL; fill_done SHALL be 1 exactly in DONE.
REQ-018 Port writes SHALL remain accepted during FILL.
REQ-019 If a port write and a FILL write target the same register on the same edge, masked port lanes SHALL take data_in and unmasked lanes SHALL take fill_value.
REQ-020 Port writes to any other register on the same edge SHALL proceed unaffected.

Reset
REQ-021 Asserting reset SHALL, without waiting for clk, clear every register lane to 0, force state IDLE and drive fill_busy=0 and fill_done=0.
REQ-022 Reset during FILL or DONE SHALL abort the fill; no further fill writes occur after reset releases.

Configuration
REQ-023 With PRF_BYPASS_EN defined: while write_enable=1 and read_addrN==write_addr (in range), data_outN SHALL return (data_in & write_lane_mask) | (current & ~write_lane_mask).
REQ-024 With PRF_BYPASS_EN defined, fill writes SHALL NOT be forwarded.
REQ-025 Without PRF_BYPASS_EN, reads SHALL return only the stored value, which updates after the edge.

Verification
REQ-026 Reset asserted mid-cycle -> all data_out read 0 immediately, fill_busy=0 and fill_done=0.
REQ-027 Write addr 3, mask 0x0000FFFF, data 0xAAAAAAAA over 0xFFFFFFFF -> read addr 3 returns 0xFFFFAAAA next cycle.
REQ-028 Fill first=30, last=1, value=1 -> busy for 4 cycles; regs 30, 31, 0, 1 = 0xFFFFFFFF, reg 2 unchanged; fill_done one pulse.
REQ-029 Fill first=5, last=5, value=0, with a same-edge port write to 5 with mask 0x1, data 0x1 -> reg 5 = 0x00000001.
REQ-030 PRF_BYPASS_EN on: write addr 7, data 0x12345678, mask all ones; read_addr1=7 same cycle -> 0x12345678. Off -> old value.
REQ-031 Reset pulsed in the 2nd cycle of a 10-register fill -> all regs 0, state IDLE, no later fill writes, no fill_done pulse.
